// File: rtl/mem_sram_pkg.sv
// Shared types and defaults for the two-phase (16+16 bit) SRAM data-memory controller.
// The state encoding and counter sizing live here so the FSM and its wait counter agree.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_SRAM_ADDR_W = 18;

  // Bits needed to count 0..wait_cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    if (wait_cycles < 2) begin
      return 1;
    end
    return $clog2(wait_cycles);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: synchronous clear has priority over enable, and `last_o`
// flags the final cycle (count == WAIT_CYCLES-1) of a half-word access.
module sram_wait_counter
  import mem_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: turns one 32-bit load/store into two timed 16-bit accesses
// (low half, then high half) on an asynchronous SRAM, holding `ready` low meanwhile.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         read_data_q, read_data_d;

  logic [31:0]         offset;
  logic                req;
  logic                in_phase;
  logic                half_sel;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_last;
  logic                unused_addr_bits;

  // Byte-offset within data memory; the subtraction wraps, so addresses below the
  // base alias onto the top of the SRAM.
  assign offset           = address - 32'(BASE_ADDR);
  assign unused_addr_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
  assign req              = rd_en | wr_en;

  assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign half_sel = (state_q == ST_HIGH);

  // The counter restarts at the end of each phase and whenever no phase is running.
  assign cnt_en  = in_phase;
  assign cnt_clr = !in_phase || cnt_last;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          word_d  = offset[SRAM_ADDR_W:2];
          wdata_d = write_data;
          is_wr_d = wr_en;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_last) begin
          state_d = ST_HIGH;
          if (!is_wr_q) begin
            read_data_d[15:0] = sram_dq_in;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          if (!is_wr_q) begin
            read_data_d[31:16] = sram_dq_in;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
    end
  end

  // SRAM pins decode only from registered state, so the strobe is glitch-free
  // relative to the address; we_n rises on the final cycle of each phase.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = {word_q, half_sel};
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    case (state_q)
      ST_IDLE: ready = !req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (in_phase && is_wr_q) begin
      sram_dq_oe  = 1'b1;
      sram_we_n   = cnt_last;
      sram_dq_out = half_sel ? wdata_q[31:16] : wdata_q[15:0];
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: directed plan items plus random loads/stores,
// checked against a 32-bit word-array reference and a per-cycle pin-rule monitor.
module tb_mem_sram_ctrl;

  localparam int W    = 5;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  mem_sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_ADDR_W (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } item_t;

  item_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;
  logic [15:0] sram    [0:262143];
  logic [31:0] ref_mem [0:131071];

  function automatic logic [15:0] init_half(input int unsigned a);
    return 16'((a * 32'd40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return off[18:2];
  endfunction

  // Asynchronous SRAM model: contents preset, then written whenever the strobe is low.
  assign sram_dq_in = sram[sram_addr];
  initial begin
    for (int a = 0; a < 262144; a++) sram[a] = init_half(a);
    sram[4] = 16'h1234;
    sram[5] = 16'hABCD;
    forever begin
      @(posedge clk);
      if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) tick();
  endtask

  // Issue one access, wait until its DONE cycle; inputs are scrambled mid-access.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data);
    item_t it;
    int    n;
    bit    ok;
    it.is_wr = wr;
    it.word  = word_of(addr);
    it.wdata = data;
    if (wr) begin
      ref_mem[it.word] = data;
      it.exp_rd = last_rd;
    end else begin
      it.exp_rd = ref_mem[it.word];
      last_rd = it.exp_rd;
    end
    sb.push_back(it);
    rd_en = rd;
    wr_en = wr;
    address = addr;
    write_data = data;
    $display("issue %s addr=%h data=%h cyc=%0d", wr ? "WR" : "RD", addr, data, cyc);
    n = 0;
    ok = 0;
    while (n < 200) begin
      tick();
      n++;
      if (ready) begin
        ok = 1;
        break;
      end
      if (n >= 2) begin
        address = $urandom;
        write_data = $urandom;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready never returned for addr %h", addr);
    end
  endtask

  // Monitor: checks every access cycle against the pin rules and pops on completion.
  initial begin
    int    low_cnt;
    bit    trace_bad;
    int    bad_k;
    item_t it;
    low_cnt = 0;
    trace_bad = 0;
    bad_k = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_cnt = 0;
        trace_bad = 0;
        sb.delete();
      end else if (!ready) begin
        if (sb.size() > 0) begin
          bit          half;
          int          p;
          logic [17:0] ea;
          bit          bad;
          it = sb[0];
          bad = 0;
          if (low_cnt == 0) begin
            bad = (sram_we_n !== 1'b1) || (sram_dq_oe !== 1'b0);
          end else if (low_cnt > 2 * W) begin
            bad = 1;
          end else begin
            half = (low_cnt > W);
            p = half ? low_cnt - W : low_cnt;
            ea = {it.word, half};
            if (sram_addr !== ea) bad = 1;
            if (it.is_wr) begin
              if (sram_dq_oe !== 1'b1) bad = 1;
              if (sram_dq_out !== (half ? it.wdata[31:16] : it.wdata[15:0])) bad = 1;
              if (sram_we_n !== (p == W)) bad = 1;
            end else begin
              if (sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1) bad = 1;
            end
          end
          if (bad && !trace_bad) begin
            trace_bad = 1;
            bad_k = low_cnt;
          end
        end
        low_cnt++;
      end else if (low_cnt > 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          it = sb.pop_front();
          chk("latency", 32'(low_cnt), 32'(2 * W + 1));
          chk("pin_trace_first_bad_cycle", trace_bad ? 32'(bad_k) : 32'hFFFFFFFF, 32'hFFFFFFFF);
          chk("read_data", read_data, it.exp_rd);
          $display("done %s word=%h read_data=%h low_cycles=%0d",
                   it.is_wr ? "WR" : "RD", it.word, read_data, low_cnt);
        end
        low_cnt = 0;
        trace_bad = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          c0;
    logic [31:0] d;
    logic [16:0] w;
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    last_rd = '0;
    for (int i = 0; i < 131072; i++) ref_mem[i] = {init_half(2 * i + 1), init_half(2 * i)};
    ref_mem[2] = 32'hABCD1234;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    rst = 1'b0;

    // No requests: bus quiet and pipeline free every cycle.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_oe", 32'(sram_dq_oe), 32'd0);
    end

    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    idle(1);
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    idle(1);
    chk("sram_word4", 32'(sram[4]), 32'h0000BEEF);
    chk("sram_word5", 32'(sram[5]), 32'h0000DEAD);

    // Back-to-back reads with rd_en held through DONE: 24 cycles for two accesses.
    idle(1);
    c0 = cyc;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    do_access(1'b1, 1'b0, 32'd1036, 32'h0);
    chk("b2b_cycles", 32'(cyc - c0 + 1), 32'd24);
    idle(1);

    do_access(1'b1, 1'b1, 32'd1040, 32'h5555AAAA);
    idle(1);
    do_access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D);
    idle(1);
    chk("wrap_lo", 32'(sram[18'h3FFFE]), 32'h0000F00D);
    chk("wrap_hi", 32'(sram[18'h3FFFF]), 32'h0000CAFE);
    do_access(1'b1, 1'b0, 32'd1020, 32'h0);
    idle(1);

    // Reset mid-write while in HIGH at counter 2 (cycle 8 after the request).
    d = 32'h13579BDF;
    w = word_of(32'd1424);
    wr_en = 1'b1;
    address = 32'd1424;
    write_data = d;
    repeat (8) tick();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_dq_out", 32'(sram_dq_out), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    ref_mem[w] = d;
    last_rd = '0;
    tick();
    chk("post_abort_we_n", 32'(sram_we_n), 32'd1);
    do_access(1'b1, 1'b0, 32'd1424, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'(BASE) + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      do_access(op != 1, op != 0, a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Multi-cycle controller for the memory stage: sequences one 32-bit data-memory access as two 16-bit accesses to an external asynchronous SRAM.
- Sits between the EX/MEM pipeline register outputs (read/write enables, ALU address, Rm value) and the MEM/WB register.
- Drives `ready`; the pipeline forms its freeze as ~ready, holding every stage until the access completes.

Parameters:
- BASE_ADDR, 1024: data-memory base; subtracted from the CPU address before mapping.
- WAIT_CYCLES, 5: cycles per 16-bit half access; legal range 2..15.
- SRAM_ADDR_W, 18: SRAM address width; equals 17 word bits + 1 half-select bit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  memory read request (MEM_R_EN from EX/MEM).
- wr_en  in  1  memory write request (MEM_W_EN from EX/MEM).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  last completed read word.
- ready  out  1  0 while an access is in progress; the pipeline freezes on 0.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  write data toward the SRAM.
- sram_dq_in  in  16  read data from the SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high, one clock.
- Reset values: state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, latched address/data/op 0. An rst during LOW/HIGH aborts the access; no further strobes occur.
- Address mapping: offset = address - BASE_ADDR, 32-bit wrapping. word = offset[18:2]. Bits [1:0] and all bits above 18 are ignored. sram_addr = {word, half}, with half = 0 for bits [15:0] and 1 for bits [31:16].
- States are IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a request: latch word, write_data and op (write if wr_en, else read), clear counter, go to LOW.
  - If rd_en and wr_en are both 1, the write wins and read_data is unchanged.
- LOW: counter counts 0..WAIT_CYCLES-1. sram_addr = {word,0}. At counter = WAIT_CYCLES-1 go to HIGH with counter 0.
- HIGH: identical to LOW with half = 1. At counter = WAIT_CYCLES-1 go to DONE.
- Write op in LOW/HIGH:
  - sram_dq_oe = 1.
  - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - sram_we_n = 0 for counter < WAIT_CYCLES-1; sram_we_n = 1 on the last cycle of each phase, so the address stays stable around the strobe edge.
- Read op in LOW/HIGH:
  - sram_dq_oe = 0, sram_we_n = 1.
  - On the last cycle of a phase, sample sram_dq_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
  - read_data is valid from the DONE cycle onward.
- DONE: ready = 1 for exactly one cycle and the pipeline advances. Return to IDLE unconditionally, even if the enables are still high. The next instruction's request is evaluated in IDLE.
- LOW, HIGH: ready = 0.
- Latency:
  - Request seen in cycle 0 → ready low in cycles 0..2*WAIT_CYCLES → ready high in cycle 2*WAIT_CYCLES+1 (DONE).
  - WAIT_CYCLES = 5: ready low for 11 cycles, high on the 12th.
- Back-to-back accesses: DONE → IDLE with a new request gives ready = 0 again in that IDLE cycle, so there is no spurious advance.
- No request: the controller stays in IDLE with ready = 1, sram_we_n = 1, sram_dq_oe = 0.
- Latched operands are used during LOW/HIGH. Input changes mid-access have no effect.

Decomposition:
- Package mem_sram_pkg:
  - state encoding enum (IDLE, LOW, HIGH, DONE).
  - default BASE_ADDR and WAIT_CYCLES constants.
  - counter width function (clog2 of WAIT_CYCLES).
- One sub-module, sram_wait_counter:
  - synchronous clear/enable counter.
  - outputs `last` when count = WAIT_CYCLES-1.
- The FSM, address mapping and data muxing stay in mem_sram_ctrl.

Test Plan:
- Reset: hold rst 3 cycles mid-write, with the controller in HIGH at counter 2 → all outputs at reset values next cycle, sram_we_n = 1, state IDLE, ready = 1 with no request.
- Write: address = 1032, write_data = 0xDEADBEEF, wr_en = 1, W = 5.
  - LOW: sram_addr = 4, dq_out = 0xBEEF, we_n low for 4 cycles then high.
  - HIGH: sram_addr = 5, dq_out = 0xDEAD, same we_n pattern.
  - ready rises exactly 11 cycles after the request.
- Read: SRAM model returns 0x1234 at addr 4 and 0xABCD at addr 5; address = 1032, rd_en = 1 → read_data = 0xABCD1234 in the DONE cycle; dq_oe stays 0 throughout.
- Back-to-back: a read with rd_en held through DONE → DONE lasts 1 cycle, IDLE with rd_en gives ready = 0, a second full access follows, total 24 cycles for two accesses.
- Conflict/wrap:
  - rd_en = wr_en = 1 → performs a write; read_data unchanged.
  - address = 1020 → offset 0xFFFFFFFC, sram_addr = 0x3FFFE then 0x3FFFF.
- Idle: no enables for 20 cycles → ready = 1, we_n = 1, dq_oe = 0 every cycle.
